// File: rtl/acc_core_pkg.sv
// Shared opcode and state definitions for the accumulator core family.
package acc_core_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h2;
    localparam logic [OP_W-1:0] OP_SUBI = 4'h3;
    localparam logic [OP_W-1:0] OP_ANDI = 4'h4;
    localparam logic [OP_W-1:0] OP_ORI  = 4'h5;
    localparam logic [OP_W-1:0] OP_XORI = 4'h6;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h7;
    localparam logic [OP_W-1:0] OP_SHR  = 4'h8;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h9;
    localparam logic [OP_W-1:0] OP_JZ   = 4'hA;
    localparam logic [OP_W-1:0] OP_JC   = 4'hB;
    localparam logic [OP_W-1:0] OP_CALL = 4'hC;
    localparam logic [OP_W-1:0] OP_RET  = 4'hD;
    localparam logic [OP_W-1:0] OP_HALT = 4'hE;
    localparam logic [OP_W-1:0] OP_RSVD = 4'hF;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/acc_core_retstack.sv
// Return-address LIFO; entry 0 is always the top of stack.
module acc_core_retstack
    import acc_core_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            CLB,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            full,
    output logic            empty
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    logic [PC_W-1:0]  mem [STACK_DEPTH];
    logic [CNT_W-1:0] count;

    assign top   = mem[0];
    assign full  = (count == CNT_W'(STACK_DEPTH));
    assign empty = (count == '0);

    // Shift-register organisation avoids a variable read index.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            count <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
        end else if (push && !full) begin
            mem[0] <= push_data;
            for (int i = 1; i < STACK_DEPTH; i++) mem[i] <= mem[i-1];
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) mem[i] <= mem[i+1];
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/acc_core_gen2.sv
// Second-generation accumulator core with flags, jumps, CALL/RET and HALT.
// Optional ACC_CORE_SAT_EN: ADDI/SUBI saturate instead of wrapping.
//
// state | meaning
// FILL  | first edge after reset, fetch pipeline not yet valid
// RUN   | execute input_ins (address pc-1)
// FLUSH | discard the stale word fetched behind a taken transfer
// HALT  | frozen until reset
module acc_core_gen2
    import acc_core_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 8,
    parameter int IMM_W       = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  CLB,
    input  logic [OP_W+IMM_W-1:0] input_ins,
    output logic [PC_W-1:0]       pc,
    output logic [DATA_W-1:0]     accum_value,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic                  halted,
    output logic                  stack_err,
    output logic                  retired
);

    state_t              state, state_nx;
    logic [PC_W-1:0]     pc_nx;
    logic [DATA_W-1:0]   acc_nx;
    logic                z_nx, c_nx, err_nx, ret_nx;
    logic [OP_W-1:0]     op;
    logic [IMM_W-1:0]    imm;
    logic [DATA_W-1:0]   imm_d;
    logic [PC_W-1:0]     imm_pc;
    logic [DATA_W:0]     sum, diff;
    logic                push, pop;
    logic [PC_W-1:0]     stk_top;
    logic                stk_full, stk_empty;

    assign op     = input_ins[IMM_W +: OP_W];
    assign imm    = input_ins[IMM_W-1:0];
    assign imm_d  = DATA_W'(imm);
    assign imm_pc = PC_W'(imm);
    assign sum    = {1'b0, accum_value} + {1'b0, imm_d};
    assign diff   = {1'b0, accum_value} - {1'b0, imm_d};
    assign halted = (state == ST_HALT);

    // In RUN, pc already equals exec_pc+1, which is the CALL return address.
    acc_core_retstack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_retstack (
        .clk       (clk),
        .CLB       (CLB),
        .push      (push),
        .pop       (pop),
        .push_data (pc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        acc_nx   = accum_value;
        z_nx     = zero_flag;
        c_nx     = carry_flag;
        err_nx   = stack_err;
        ret_nx   = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        case (state)
            ST_FILL, ST_FLUSH: begin
                pc_nx    = pc + PC_W'(1);
                state_nx = ST_RUN;
            end
            ST_RUN: begin
                pc_nx  = pc + PC_W'(1);
                ret_nx = 1'b1;
                case (op)
                    OP_LDI:  acc_nx = imm_d;
                    OP_ADDI: begin
                        c_nx   = sum[DATA_W];
                        acc_nx = sum[DATA_W-1:0];
`ifdef ACC_CORE_SAT_EN
                        if (sum[DATA_W]) acc_nx = '1;
`endif
                    end
                    OP_SUBI: begin
                        c_nx   = diff[DATA_W];
                        acc_nx = diff[DATA_W-1:0];
`ifdef ACC_CORE_SAT_EN
                        if (diff[DATA_W]) acc_nx = '0;
`endif
                    end
                    OP_ANDI: acc_nx = accum_value & imm_d;
                    OP_ORI:  acc_nx = accum_value | imm_d;
                    OP_XORI: acc_nx = accum_value ^ imm_d;
                    OP_SHL:  acc_nx = accum_value << imm;
                    OP_SHR:  acc_nx = accum_value >> imm;
                    OP_JMP: begin
                        pc_nx    = imm_pc;
                        state_nx = ST_FLUSH;
                    end
                    OP_JZ: if (zero_flag) begin
                        pc_nx    = imm_pc;
                        state_nx = ST_FLUSH;
                    end
                    OP_JC: if (carry_flag) begin
                        pc_nx    = imm_pc;
                        state_nx = ST_FLUSH;
                    end
                    OP_CALL: if (stk_full) begin
                        err_nx = 1'b1;
                    end else begin
                        push     = 1'b1;
                        pc_nx    = imm_pc;
                        state_nx = ST_FLUSH;
                    end
                    OP_RET: if (stk_empty) begin
                        err_nx = 1'b1;
                    end else begin
                        pop      = 1'b1;
                        pc_nx    = stk_top;
                        state_nx = ST_FLUSH;
                    end
                    OP_HALT: state_nx = ST_HALT;
                    default: ;
                endcase
                if (op >= OP_LDI && op <= OP_SHR) z_nx = (acc_nx == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state       <= ST_FILL;
            pc          <= '0;
            accum_value <= '0;
            zero_flag   <= 1'b0;
            carry_flag  <= 1'b0;
            stack_err   <= 1'b0;
            retired     <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            accum_value <= acc_nx;
            zero_flag   <= z_nx;
            carry_flag  <= c_nx;
            stack_err   <= err_nx;
            retired     <= ret_nx;
        end
    end

endmodule

// File: tb/tb_acc_core_gen2.sv
// Self-checking bench: directed programs plus random ROMs against an ISA-level model.
module tb_acc_core_gen2;

    localparam int DATA_W = 8, PC_W = 8, IMM_W = 4, STACK_DEPTH = 4, PC_N = 256;

    logic             clk = 1'b0;
    logic             CLB = 1'b0;
    logic [7:0]       input_ins;
    logic [PC_W-1:0]  pc;
    logic [DATA_W-1:0] accum_value;
    logic             zero_flag, carry_flag, halted, stack_err, retired;

    logic [7:0]       rom [PC_N];
    logic [PC_W-1:0]  fetch_addr = '0;

    int checks = 0;
    int errors = 0;

    int m_pc, m_acc;
    bit m_z, m_c, m_halt, m_err, m_ret, m_bubble;
    int m_stack[$];

    acc_core_gen2 #(
        .DATA_W(DATA_W), .PC_W(PC_W), .IMM_W(IMM_W), .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk(clk), .CLB(CLB), .input_ins(input_ins), .pc(pc),
        .accum_value(accum_value), .zero_flag(zero_flag), .carry_flag(carry_flag),
        .halted(halted), .stack_err(stack_err), .retired(retired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) fetch_addr <= pc;
    assign input_ins = rom[fetch_addr];

    function automatic logic [20:0] dut_vec();
        return {pc, accum_value, zero_flag, carry_flag, halted, stack_err, retired};
    endfunction

    function automatic logic [20:0] model_vec();
        return {8'(m_pc), 8'(m_acc), m_z, m_c, m_halt, m_err, m_ret};
    endfunction

    task automatic model_reset();
        m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_halt = 0; m_err = 0; m_ret = 0;
        m_bubble = 1;
        m_stack.delete();
    endtask

    // One clock edge of architectural behaviour.
    task automatic model_step();
        int ex, ins, op, imm, r;
        if (m_halt) begin m_ret = 0; return; end
        if (m_bubble) begin
            m_pc = (m_pc + 1) % PC_N; m_bubble = 0; m_ret = 0; return;
        end
        ex  = (m_pc + PC_N - 1) % PC_N;
        ins = int'(rom[ex]);
        op  = (ins >> 4) & 15;
        imm = ins & 15;
        m_ret = 1;
        m_pc  = (m_pc + 1) % PC_N;
        case (op)
            1: m_acc = imm;
            2: begin
                r = m_acc + imm; m_c = (r > 255);
`ifdef ACC_CORE_SAT_EN
                m_acc = m_c ? 255 : r;
`else
                m_acc = r % 256;
`endif
            end
            3: begin
                r = m_acc - imm; m_c = (r < 0);
`ifdef ACC_CORE_SAT_EN
                m_acc = m_c ? 0 : r;
`else
                m_acc = (r + 256) % 256;
`endif
            end
            4: m_acc = m_acc & imm;
            5: m_acc = m_acc | imm;
            6: m_acc = m_acc ^ imm;
            7: m_acc = (imm >= DATA_W) ? 0 : (m_acc << imm) % 256;
            8: m_acc = (imm >= DATA_W) ? 0 : (m_acc >> imm);
            9: begin m_pc = imm; m_bubble = 1; end
            10: if (m_z) begin m_pc = imm; m_bubble = 1; end
            11: if (m_c) begin m_pc = imm; m_bubble = 1; end
            12: if (m_stack.size() == STACK_DEPTH) m_err = 1;
                else begin m_stack.push_back((ex + 1) % PC_N); m_pc = imm; m_bubble = 1; end
            13: if (m_stack.size() == 0) m_err = 1;
                else begin m_pc = m_stack.pop_back(); m_bubble = 1; end
            14: m_halt = 1;
            default: ;
        endcase
        if (op >= 1 && op <= 8) m_z = (m_acc == 0);
    endtask

    task automatic rom_clear();
        foreach (rom[i]) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        CLB = 1'b0;
        model_reset();
        @(negedge clk);
        CLB = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (dut_vec() !== 21'h0) begin
            errors++; $display("FAIL reset_state: got %h want %h", dut_vec(), 21'h0);
        end
    endtask

    task automatic test_basic();
        rom_clear(); rom[0] = 8'h15; rom[1] = 8'h23;
        do_reset();
        tick();
        checks++;
        if ({pc, retired} !== {8'd1, 1'b0}) begin
            errors++; $display("FAIL basic_fill: got pc=%0d ret=%0b want pc=1 ret=0", pc, retired);
        end
        tick();
        checks++;
        if ({accum_value, retired} !== {8'h05, 1'b1}) begin
            errors++; $display("FAIL basic_ldi: got acc=%h ret=%0b want acc=05 ret=1", accum_value, retired);
        end
        tick();
        checks++;
        if ({accum_value, zero_flag, carry_flag, pc} !== {8'h08, 1'b0, 1'b0, 8'd3}) begin
            errors++; $display("FAIL basic_addi: got acc=%h z=%0b c=%0b pc=%0d want 08 0 0 3",
                               accum_value, zero_flag, carry_flag, pc);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL basic_model: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_flags();
        logic [9:0] want;
        rom_clear(); rom[0] = 8'h1F; rom[1] = 8'h74; rom[2] = 8'h2F; rom[3] = 8'h21;
        do_reset();
        repeat (3) tick();
        checks++;
        if (accum_value !== 8'hF0) begin
            errors++; $display("FAIL flags_shl: got %h want f0", accum_value);
        end
        tick();
        checks++;
        if ({accum_value, carry_flag} !== {8'hFF, 1'b0}) begin
            errors++; $display("FAIL flags_ff: got acc=%h c=%0b want ff 0", accum_value, carry_flag);
        end
        tick();
`ifdef ACC_CORE_SAT_EN
        want = {8'hFF, 1'b1, 1'b0};
`else
        want = {8'h00, 1'b1, 1'b1};
`endif
        checks++;
        if ({accum_value, carry_flag, zero_flag} !== want) begin
            errors++; $display("FAIL flags_carry: got acc=%h c=%0b z=%0b want %h",
                               accum_value, carry_flag, zero_flag, want);
        end
    endtask

    task automatic test_jump();
        rom_clear();
        rom[0] = 8'h11; rom[1] = 8'hA9; rom[2] = 8'h98; rom[3] = 8'h17; rom[8] = 8'h22;
        do_reset();
        repeat (3) tick();
        checks++;
        if ({pc, retired} !== {8'd3, 1'b1}) begin
            errors++; $display("FAIL jz_not_taken: got pc=%0d ret=%0b want 3 1", pc, retired);
        end
        tick();
        checks++;
        if ({pc, retired} !== {8'd8, 1'b1}) begin
            errors++; $display("FAIL jmp_taken: got pc=%0d ret=%0b want 8 1", pc, retired);
        end
        tick();
        checks++;
        if ({pc, retired, accum_value} !== {8'd9, 1'b0, 8'h01}) begin
            errors++; $display("FAIL jmp_squash: got pc=%0d ret=%0b acc=%h want 9 0 01",
                               pc, retired, accum_value);
        end
        tick();
        checks++;
        if ({pc, retired, accum_value} !== {8'd10, 1'b1, 8'h03}) begin
            errors++; $display("FAIL jmp_target: got pc=%0d ret=%0b acc=%h want 10 1 03",
                               pc, retired, accum_value);
        end
    endtask

    task automatic test_call();
        rom_clear(); rom[1] = 8'hC6; rom[2] = 8'h19; rom[6] = 8'hD0;
        do_reset();
        repeat (7) tick();
        checks++;
        if ({accum_value, pc, stack_err, retired} !== {8'h09, 8'd4, 1'b0, 1'b1}) begin
            errors++; $display("FAIL call_ret: got acc=%h pc=%0d err=%0b ret=%0b want 09 4 0 1",
                               accum_value, pc, stack_err, retired);
        end
        rom_clear();
        for (int i = 0; i < 5; i++) rom[i] = 8'hC0 | 8'(i + 1);
        do_reset();
        repeat (10) tick();
        checks++;
        if ({stack_err, pc, retired} !== {1'b1, 8'd6, 1'b1}) begin
            errors++; $display("FAIL call_overflow: got err=%0b pc=%0d ret=%0b want 1 6 1",
                               stack_err, pc, retired);
        end
        tick();
        checks++;
        if ({pc, retired} !== {8'd7, 1'b1}) begin
            errors++; $display("FAIL call_overflow_nobubble: got pc=%0d ret=%0b want 7 1", pc, retired);
        end
        rom_clear(); rom[0] = 8'hD0; rom[1] = 8'hD0;
        do_reset();
        #1;
        checks++;
        if (stack_err !== 1'b0) begin
            errors++; $display("FAIL stack_reset: got err=%0b want 0", stack_err);
        end
        repeat (2) tick();
        checks++;
        if ({stack_err, pc} !== {1'b1, 8'd2}) begin
            errors++; $display("FAIL ret_empty: got err=%0b pc=%0d want 1 2", stack_err, pc);
        end
        tick();
        checks++;
        if ({stack_err, pc} !== {1'b1, 8'd3}) begin
            errors++; $display("FAIL ret_empty_sticky: got err=%0b pc=%0d want 1 3", stack_err, pc);
        end
    endtask

    task automatic test_halt();
        rom_clear(); rom[0] = 8'h13; rom[4] = 8'hE0; rom[5] = 8'h1F;
        do_reset();
        repeat (6) tick();
        checks++;
        if ({halted, pc, accum_value, retired} !== {1'b1, 8'd6, 8'h03, 1'b1}) begin
            errors++; $display("FAIL halt_enter: got h=%0b pc=%0d acc=%h ret=%0b want 1 6 03 1",
                               halted, pc, accum_value, retired);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({halted, pc, accum_value, retired} !== {1'b1, 8'd6, 8'h03, 1'b0}) begin
                errors++; $display("FAIL halt_hold[%0d]: got h=%0b pc=%0d acc=%h ret=%0b want 1 6 03 0",
                                   i, halted, pc, accum_value, retired);
            end
        end
        @(posedge clk);
        #2;
        CLB = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 21'h0) begin
            errors++; $display("FAIL halt_async_reset: got %h want %h", dut_vec(), 21'h0);
        end
    endtask

    task automatic test_random();
        int op;
        for (int round = 0; round < 4; round++) begin
            foreach (rom[i]) begin
                op = $urandom_range(0, 15);
                if (op == 14 && $urandom_range(0, 19) != 0) op = 0;
                rom[i] = {4'(op), 4'($urandom_range(0, 15))};
            end
            do_reset();
            for (int cyc = 0; cyc < 400; cyc++) begin
                tick();
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++; $display("FAIL random[%0d.%0d]: got %h want %h",
                                       round, cyc, dut_vec(), model_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_flags();
        test_jump();
        test_call();
        test_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_core_gen2.md
Name: acc_core_gen2

Overview:
Parametrised second-generation accumulator core. It is driven by an external instruction memory whose address register is loaded from pc on every rising clk edge. Adds over the first core: configurable data/PC/immediate widths, zero/carry flags, conditional jumps, CALL/RET with a hardware return stack, HALT, and squash of the stale fetch after any taken control transfer. Sits between the instruction ROM/bench and any accumulator-observing logic.

Parameters:
DATA_W, 8, accumulator width (>=4)
PC_W, 8, program counter width; jump targets are imm zero-extended to PC_W
IMM_W, 4, immediate field width; instruction width = 4 + IMM_W
STACK_DEPTH, 4, return-stack entries (>=1)

Ports:
clk  in  1  rising-edge clock
CLB  in  1  asynchronous active-low reset
input_ins  in  4+IMM_W  instruction; op = [IMM_W+3:IMM_W], imm = [IMM_W-1:0]; it is the word at the pc value registered one edge earlier
pc  out  PC_W  program counter (fetch address)
accum_value  out  DATA_W  accumulator
zero_flag  out  1  Z
carry_flag  out  1  C (borrow for SUBI)
halted  out  1  core in HALT
stack_err  out  1  sticky: push when full or pop when empty
retired  out  1  1 on the cycle following an edge that executed a non-squashed instruction

Behaviour:
- Reset (CLB=0, async): pc=0, accum_value=0, Z=0, C=0, halted=0, stack_err=0, retired=0, stack empty, state=FILL.
- States: FILL, RUN, FLUSH, HALT.
- FILL: first edge after reset release; input_ins ignored; pc<=pc+1; ->RUN.
- RUN: execute input_ins; executing address is pc-1 (exec_pc); default pc<=pc+1 (wraps mod 2^PC_W).
- Opcodes: 0 NOP; 1 LDI acc=zext(imm); 2 ADDI acc+=zext(imm), C=carry out; 3 SUBI acc-=zext(imm), C=borrow; 4 ANDI; 5 ORI; 6 XORI; 7 SHL by imm; 8 SHR by imm (logical; imm>=DATA_W gives 0); 9 JMP; A JZ (taken if Z); B JC (taken if C); C CALL; D RET; E HALT; F reserved = NOP.
- Z updated by opcodes 1-8 (Z = result==0). C updated by 2,3 only; other ops leave C unchanged.
- Taken JMP/JZ/JC/CALL/RET: pc<=target; ->FLUSH. Not-taken conditional: no bubble.
- CALL pushes exec_pc+1, target=imm. RET pops; target=popped value.
- CALL with stack full or RET with stack empty: stack_err<=1, no push/pop, no jump, treated as NOP.
- FLUSH: input_ins (stale word at exec_pc+1) ignored; pc<=pc+1; retired=0; ->RUN.
- HALT: pc, acc, flags frozen; halted=1; exit only by reset.
- retired: registered; 1 after every RUN-state execute (including NOP/reserved/error cases and the HALT instruction itself); 0 after FILL/FLUSH/HALT cycles.
- Reset mid-FLUSH/HALT/mid-stack use: everything returns to reset values immediately; stack contents discarded.

Optional Feature:
ACC_CORE_SAT_EN: defined -> ADDI saturates at 2^DATA_W-1 and SUBI at 0; C still reports the overflow/borrow; Z from the saturated result. Undefined -> ADDI/SUBI wrap mod 2^DATA_W.

Decomposition:
- Package acc_core_pkg: opcode localparams (OP_NOP..OP_RSVD), state encoding, op-field width constant 4.
- One sub-module: acc_core_retstack (LIFO, parameters PC_W/STACK_DEPTH; push/pop/full/empty, async active-low reset). ALU stays inline.

Test Plan:
- Reset release, ROM: 0:LDI 5, 1:ADDI 3 -> first edge retired=0, pc 0->1; then acc=0x05, then 0x08, Z=0, C=0, pc=3.
- LDI F, SHL 4, ADDI F, ADDI 1 -> acc 0xF0, 0xFF, 0x00 with C=1, Z=1; with ACC_CORE_SAT_EN final acc=0xFF, C=1, Z=0.
- 2:JMP 8 with 3:LDI 7 -> address 3 squashed (acc unchanged, retired=0 one cycle), next executed is mem[8]; JZ with Z=0 -> no bubble, pc continues.
- 1:CALL 6, 6:RET -> next executed is address 2; five nested CALLs with STACK_DEPTH=4 -> fifth sets stack_err=1, no jump; RET with empty stack -> stack_err stays 1, pc+1.
- HALT at 4 -> halted=1, pc and acc constant for 10 cycles; CLB low mid-HALT -> pc=0, acc=0, halted=0, stack_err=0 without waiting for clk.
